// File: rtl/aurora_rx_pkg.sv
// Shared constants and FSM state encoding for the Aurora RX deframer.
package aurora_rx_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        S_RX_IDLE = 2'd0,
        S_RX_DATA = 2'd1,
        S_RX_DROP = 2'd2
    } rx_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/aurora_rx_ram.sv
// Simple dual-port frame buffer: one synchronous write port, one asynchronous
// read port so the output stage can load a word in the same cycle it addresses it.
module aurora_rx_ram
    import aurora_rx_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = WORD_W + 1
)
(
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/aurora_rx_deframer.sv
// Buffers Aurora RX frames and releases only complete, length-checked frames on
// a backpressured AXI-Stream master. Optional stats counters: AURORA_RX_STATS_EN.
module aurora_rx_deframer
    import aurora_rx_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6,
    parameter int MAX_WORDS  = 32
)
(
    input  logic              s_axis_aclk,
    input  logic              s_axis_areset,
    input  logic              s_axis_tvalid,
    input  logic [WORD_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    output logic              m_axis_tvalid,
    output logic [WORD_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
`ifdef AURORA_RX_STATS_EN
    output logic [CNT_W-1:0]  frames_ok,
    output logic [CNT_W-1:0]  frames_dropped,
`endif
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_len
);

    localparam int                PTR_W    = DEPTH_LOG2 + 1;
    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [PTR_W-1:0]  FULL_LVL = PTR_W'(DEPTH);
    localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_WORDS);

    rx_state_e          r_state;
    rx_state_e          w_state_next;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_wr_commit;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_word_cnt;
    logic [CNT_W-1:0]   r_frame_len;
    logic               r_frame_done;
    logic               r_out_valid;
    logic [WORD_W-1:0]  r_out_data;
    logic               r_out_last;

    logic               w_full;
    logic               w_empty;
    logic               w_wr_en;
    logic               w_rewind;
    logic               w_commit;
    logic               w_drop_cnt;
    logic               w_load;
    logic [WORD_W:0]    w_rd_word;

    // Full uses the registered read pointer, so a read frees space only next cycle.
    assign w_full  = (r_wr_ptr - r_rd_ptr) == FULL_LVL;
    assign w_empty = (r_rd_ptr == r_wr_commit);
    assign w_load  = !w_empty && (!r_out_valid || m_axis_tready);

    aurora_rx_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (WORD_W + 1)
    ) u_ram (
        .i_clk     (s_axis_aclk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[DEPTH_LOG2-1:0]),
        .i_wr_data ({s_axis_tlast, s_axis_tdata}),
        .i_rd_addr (r_rd_ptr[DEPTH_LOG2-1:0]),
        .o_rd_data (w_rd_word)
    );

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_state <= S_RX_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_wr_en      = 1'b0;
        w_rewind     = 1'b0;
        w_commit     = 1'b0;
        w_drop_cnt   = 1'b0;
        case (r_state)
            S_RX_IDLE, S_RX_DATA: begin
                if (s_axis_tvalid) begin
                    if (w_full || (r_word_cnt == MAX_CNT)) begin
                        // Rejected frame: roll back everything written for it.
                        w_rewind = 1'b1;
                        if (s_axis_tlast) begin
                            w_drop_cnt   = 1'b1;
                            w_state_next = S_RX_IDLE;
                        end else begin
                            w_state_next = S_RX_DROP;
                        end
                    end else begin
                        w_wr_en = 1'b1;
                        if (s_axis_tlast) begin
                            w_commit     = 1'b1;
                            w_state_next = S_RX_IDLE;
                        end else begin
                            w_state_next = S_RX_DATA;
                        end
                    end
                end
            end
            S_RX_DROP: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    w_drop_cnt   = 1'b1;
                    w_state_next = S_RX_IDLE;
                end
            end
            default: begin
                w_state_next = S_RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_wr_ptr     <= '0;
            r_wr_commit  <= '0;
            r_word_cnt   <= '0;
            r_frame_len  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end else if (w_rewind) begin
                r_wr_ptr <= r_wr_commit;
            end
            if (w_commit || w_rewind) begin
                r_word_cnt <= '0;
            end else if (w_wr_en) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
            if (w_commit) begin
                r_wr_commit <= r_wr_ptr + 1'b1;
                r_frame_len <= r_word_cnt + 1'b1;
            end
            r_frame_done <= w_commit;
        end
    end

    // First-word-fall-through output register; holds its word while stalled.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_load) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_out_valid <= 1'b1;
                r_out_data  <= w_rd_word[WORD_W-1:0];
                r_out_last  <= w_rd_word[WORD_W];
            end else if (m_axis_tready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef AURORA_RX_STATS_EN
    logic [CNT_W-1:0] r_frames_ok;
    logic [CNT_W-1:0] r_frames_dropped;

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_frames_ok      <= '0;
            r_frames_dropped <= '0;
        end else begin
            if (w_commit) begin
                r_frames_ok <= sat_inc(r_frames_ok);
            end
            if (w_drop_cnt) begin
                r_frames_dropped <= sat_inc(r_frames_dropped);
            end
        end
    end

    assign frames_ok      = r_frames_ok;
    assign frames_dropped = r_frames_dropped;
`endif

    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tlast  = r_out_last;
    assign frame_done    = r_frame_done;
    assign frame_len     = r_frame_len;

endmodule

// File: tb/tb_aurora_rx_deframer.sv
// Scoreboard bench for aurora_rx_deframer: a queue-based frame model predicts
// committed words, output valid, frame_done timing and drop behaviour.
module tb_aurora_rx_deframer;

    localparam int DEPTH = 64;
    localparam int MAXW  = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_v = 1'b0;
    logic [31:0] in_d = '0;
    logic        in_l = 1'b0;
    logic        rdy = 1'b0;
    bit          rdy_rand = 1'b0;
    logic        out_v;
    logic [31:0] out_d;
    logic        out_l;
    logic        done;
    logic [15:0] flen;
`ifdef AURORA_RX_STATS_EN
    logic [15:0] st_ok;
    logic [15:0] st_drop;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [32:0] exp_q[$];
    logic [31:0] part_q[$];
    int          done_cyc_q[$];
    int          done_len_q[$];
    int          buf_cnt = 0;
    bit          m_valid = 1'b0;
    bit          dropping = 1'b0;
    int          m_ok = 0;
    int          m_drop = 0;
    int          cyc = 0;
    int          hs_cnt = 0;
    int          hs_last = 0;

    always #5 clk = ~clk;

    aurora_rx_deframer #(.DEPTH_LOG2(6), .MAX_WORDS(MAXW)) dut (
        .s_axis_aclk    (clk),
        .s_axis_areset  (rst),
        .s_axis_tvalid  (in_v),
        .s_axis_tdata   (in_d),
        .s_axis_tlast   (in_l),
        .m_axis_tvalid  (out_v),
        .m_axis_tdata   (out_d),
        .m_axis_tlast   (out_l),
        .m_axis_tready  (rdy),
`ifdef AURORA_RX_STATS_EN
        .frames_ok      (st_ok),
        .frames_dropped (st_drop),
`endif
        .frame_done     (done),
        .frame_len      (flen)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        part_q.delete();
        done_cyc_q.delete();
        done_len_q.delete();
        buf_cnt  = 0;
        m_valid  = 1'b0;
        dropping = 1'b0;
        m_ok     = 0;
        m_drop   = 0;
    endtask

    // Predicts the effect of the coming clock edge from the current inputs.
    task automatic model_step();
        int occ;
        bit load;
        occ  = part_q.size() + buf_cnt;
        load = (buf_cnt > 0) && (!m_valid || rdy);
        if (load) begin
            buf_cnt--;
            m_valid = 1'b1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        if (in_v) begin
            if (dropping) begin
                if (in_l) begin
                    dropping = 1'b0;
                    m_drop   = sat(m_drop);
                end
            end else if (occ == DEPTH || part_q.size() == MAXW) begin
                part_q.delete();
                if (in_l) m_drop = sat(m_drop);
                else dropping = 1'b1;
            end else begin
                part_q.push_back(in_d);
                if (in_l) begin
                    for (int i = 0; i < part_q.size(); i++)
                        exp_q.push_back({(i == part_q.size() - 1) ? 1'b1 : 1'b0, part_q[i]});
                    buf_cnt += part_q.size();
                    done_cyc_q.push_back(cyc + 1);
                    done_len_q.push_back(part_q.size());
                    m_ok = sat(m_ok);
                    part_q.delete();
                end
            end
        end
    endtask

    // Monitor: compares DUT outputs each falling edge, then advances the model.
    initial begin
        bit exp_done;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_clear();
            end else begin
                chk("tvalid", out_v, m_valid);
                if (out_v) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", out_d, 0);
                    end else begin
                        chk("tdata", out_d, exp_q[0][31:0]);
                        chk("tlast", out_l, exp_q[0][32]);
                    end
                    if (rdy) begin
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        hs_cnt++;
                        if (out_l) hs_last++;
                    end
                end
                exp_done = (done_cyc_q.size() > 0) && (done_cyc_q[0] == cyc);
                chk("frame_done", done, exp_done);
                if (exp_done) begin
                    chk("frame_len", flen, done_len_q[0]);
                    void'(done_cyc_q.pop_front());
                    void'(done_len_q.pop_front());
                end
                model_step();
                cyc++;
            end
        end
    end

    task automatic tick(input bit v, input logic [31:0] d, input bit l);
        in_v = v;
        in_d = d;
        in_l = l;
        if (rdy_rand) rdy = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        in_v = 1'b0;
        in_l = 1'b0;
    endtask

    task automatic send_frame(input int len, input int gap_max);
        for (int i = 0; i < len; i++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick(1'b0, '0, 1'b0);
            tick(1'b1, $urandom, (i == len - 1));
        end
    endtask

    task automatic drain();
        rdy_rand = 1'b0;
        rdy      = 1'b1;
        for (int i = 0; i < 400 && (exp_q.size() > 0 || done_cyc_q.size() > 0); i++)
            tick(1'b0, '0, 1'b0);
        chk("drain_left", exp_q.size(), 0);
        tick(1'b0, '0, 1'b0);
    endtask

    task automatic check_stats(input string tag);
`ifdef AURORA_RX_STATS_EN
        chk({tag, "_frames_ok"}, st_ok, m_ok);
        chk({tag, "_frames_dropped"}, st_drop, m_drop);
`endif
    endtask

    task automatic reset_pulse(input string tag);
        rst  = 1'b1;
        in_v = 1'b0;
        in_l = 1'b0;
        #1;
        chk({tag, "_tvalid0"}, out_v, 0);
        chk({tag, "_tdata0"}, out_d, 0);
        chk({tag, "_tlast0"}, out_l, 0);
        chk({tag, "_done0"}, done, 0);
        chk({tag, "_len0"}, flen, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int h0;
        int l0;
        #12;
        chk("rst_tvalid", out_v, 0);
        chk("rst_tdata", out_d, 0);
        chk("rst_tlast", out_l, 0);
        chk("rst_done", done, 0);
        chk("rst_len", flen, 0);
        check_stats("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Two-word frame {5,3}
        rdy = 1'b1;
        tick(1'b1, 32'h5, 1'b0);
        tick(1'b1, 32'h3, 1'b1);
        drain();
        chk("t1_frame_len", flen, 2);
        check_stats("t1");

        // Oversized frame is dropped, following frame passes
        send_frame(MAXW + 1, 0);
        send_frame(2, 0);
        drain();
        check_stats("t2");

        // Three back-to-back 32-word frames with output stalled
        rdy = 1'b0;
        send_frame(32, 0);
        send_frame(32, 0);
        send_frame(32, 0);
        h0 = hs_cnt;
        l0 = hs_last;
        drain();
        chk("t3_words", hs_cnt - h0, 64);
        chk("t3_lasts", hs_last - l0, 2);
        check_stats("t3");

        // Single-word frames every cycle with random backpressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 200; i++) tick(1'b1, $urandom, 1'b1);
        drain();
        check_stats("t4");

        // Reset mid-frame with a buffered frame pending
        rdy = 1'b0;
        send_frame(4, 0);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        send_frame(3, 0);
        reset_pulse("rst_midframe");
        send_frame(8, 0);
        drain();
        chk("t5_len_after_rst", flen, 8);

        // Reset mid-output
        rdy = 1'b1;
        send_frame(20, 0);
        repeat (4) tick(1'b0, '0, 1'b0);
        reset_pulse("rst_midout");
        send_frame(5, 1);
        drain();
        check_stats("t5");

        // Random frames, gaps and backpressure
        rdy_rand = 1'b1;
        for (int f = 0; f < 40; f++) send_frame($urandom_range(1, 36), 2);
        drain();
        check_stats("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
